// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg: FSM state encoding and default repeat timing shared by the step_ctrl slice.
`ifndef STEP_REPEAT_DELAY
`define STEP_REPEAT_DELAY 50_000_000
`endif
`ifndef STEP_REPEAT_PERIOD
`define STEP_REPEAT_PERIOD 10_000_000
`endif
package step_ctrl_pkg;
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } st_e;
   localparam int DEF_REPEAT_DELAY  = `STEP_REPEAT_DELAY;
   localparam int DEF_REPEAT_PERIOD = `STEP_REPEAT_PERIOD;
endpackage

// File: rtl/step_ctrl_rise.sv
// rise_pulse: registered rising-edge detector for a debounced level.
module rise_pulse (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);
   logic q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= 1'b0;
      else q <= d;
   assign rise = d && !q;
endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: CPU clock-enable from step/mode buttons, with run mode and a step pulse counter.
// Held-button auto-repeat is built only when STEP_AUTOREPEAT_EN is defined.
module step_ctrl
   import step_ctrl_pkg::*;
#(
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
   parameter bit RUN_AT_RESET  = 1'b0,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             efct_step,
   input  logic             efct_mode,
   output logic             cpu_en,
   output logic             run_mode,
   output logic [CNT_W-1:0] step_cnt
);
   if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_chk
      $error("step_ctrl: REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
   end
   logic step_rise, mode_rise, pulse, run_nx;
   st_e st;
   rise_pulse u_step (.clk(clk), .rst_n(rst_n), .d(efct_step), .rise(step_rise));
   rise_pulse u_mode (.clk(clk), .rst_n(rst_n), .d(efct_mode), .rise(mode_rise));
   assign run_nx = run_mode ^ mode_rise;
`ifdef STEP_AUTOREPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW = $clog2(RPT_MAX);
   localparam logic [RW-1:0] DLY_END = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PER_END = RW'(REPEAT_PERIOD - 1);
   logic [RW-1:0] rpt_cnt;
   logic hold_end, rpt_end;
   assign hold_end = st == ST_HOLD && rpt_cnt == DLY_END;
   assign rpt_end  = st == ST_REPEAT && rpt_cnt == PER_END;
   // A mode toggle pre-empts a repeat pulse landing on the same cycle
   assign pulse = !run_mode && (st == ST_IDLE ? step_rise : efct_step && !mode_rise && (hold_end || rpt_end));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rpt_cnt <= '0;
      else rpt_cnt <= (run_mode || mode_rise || st == ST_IDLE || !efct_step || hold_end || rpt_end) ? '0 : rpt_cnt + 1'b1;
`else
   assign pulse = !run_mode && st == ST_IDLE && step_rise;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cpu_en   <= 1'b0;
         run_mode <= RUN_AT_RESET;
         step_cnt <= '0;
         st       <= ST_IDLE;
      end else begin
         cpu_en   <= run_nx || pulse;
         run_mode <= run_nx;
         if (pulse) step_cnt <= step_cnt + 1'b1;
         if (run_mode || mode_rise) st <= ST_IDLE;
         else if (st == ST_IDLE) begin
            if (step_rise) st <= ST_HOLD;
         end
         else if (!efct_step) st <= ST_IDLE;
`ifdef STEP_AUTOREPEAT_EN
         else if (hold_end) st <= ST_REPEAT;
`endif
      end
endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: directed checks of step_ctrl with REPEAT_DELAY=8, REPEAT_PERIOD=4, CNT_W=4.
module tb_step_ctrl;
   logic clk = 1'b0;
   logic rst_n, efct_step, efct_mode, cpu_en, run_mode;
   logic [3:0] step_cnt;
   int checks = 0, failures = 0, exp_cnt = 0;
   step_ctrl #(.REPEAT_DELAY(8), .REPEAT_PERIOD(4), .RUN_AT_RESET(1'b0), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .efct_step(efct_step), .efct_mode(efct_mode),
      .cpu_en(cpu_en), .run_mode(run_mode), .step_cnt(step_cnt));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic int rpt_exp(input int k);
`ifdef STEP_AUTOREPEAT_EN
      return (k == 0 || k == 8 || k == 12 || k == 16) ? 1 : 0;
`else
      return (k == 0) ? 1 : 0;
`endif
   endfunction
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      rst_n = 1'b0; efct_step = 1'b0; efct_mode = 1'b0;
      repeat (3) tick();
      chk("rst_en", cpu_en, 0);
      chk("rst_run", run_mode, 0);
      chk("rst_cnt", step_cnt, 0);
      rst_n = 1'b1;
      repeat (5) tick();
      // single press held for 3 cycles: one pulse, latency 1
      efct_step = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("single_en", cpu_en, k == 0 ? 1 : 0);
      end
      efct_step = 1'b0;
      tick();
      chk("single_rel", cpu_en, 0);
      exp_cnt += 1;
      chk("single_cnt", step_cnt, exp_cnt % 16);
      chk("single_run", run_mode, 0);
      // long hold: auto-repeat after 8, then every 4
      efct_step = 1'b1;
      for (int k = 0; k < 17; k++) begin
         tick();
         chk("hold_en", cpu_en, rpt_exp(k));
      end
      efct_step = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("hold_rel", cpu_en, 0);
      end
`ifdef STEP_AUTOREPEAT_EN
      exp_cnt += 4;
`else
      exp_cnt += 1;
`endif
      chk("hold_cnt", step_cnt, exp_cnt % 16);
      // run mode: enable constant, steps ignored
      efct_mode = 1'b1;
      tick();
      chk("run_on", run_mode, 1);
      chk("run_en", cpu_en, 1);
      efct_mode = 1'b0;
      tick();
      efct_step = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("run_en_hold", cpu_en, 1);
      end
      efct_step = 1'b0;
      tick();
      chk("run_cnt", step_cnt, exp_cnt % 16);
      efct_mode = 1'b1;
      tick();
      chk("run_off", run_mode, 0);
      chk("run_off_en", cpu_en, 0);
      efct_mode = 1'b0;
      repeat (2) tick();
      // simultaneous step and mode rise in step mode
      efct_step = 1'b1; efct_mode = 1'b1;
      tick();
      exp_cnt += 1;
      chk("sim_en", cpu_en, 1);
      chk("sim_run", run_mode, 1);
      chk("sim_cnt", step_cnt, exp_cnt % 16);
      efct_mode = 1'b0;
      tick();
      chk("sim_en2", cpu_en, 1);
      // back to step mode with step still held: no pulse until re-press
      efct_mode = 1'b1;
      tick();
      chk("r2s_run", run_mode, 0);
      chk("r2s_en", cpu_en, 0);
      efct_mode = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("r2s_held", cpu_en, 0);
      end
      efct_step = 1'b0;
      tick();
      efct_step = 1'b1;
      tick();
      chk("r2s_press", cpu_en, 1);
      tick();
      chk("r2s_press2", cpu_en, 0);
      efct_step = 1'b0;
      tick();
      exp_cnt += 1;
      chk("r2s_cnt", step_cnt, exp_cnt % 16);
      // counter wrap to zero
      for (int k = 0; k < 16 - (exp_cnt % 16); k++) begin
         efct_step = 1'b1;
         tick();
         efct_step = 1'b0;
         tick();
      end
      chk("wrap_cnt", step_cnt, 0);
      // asynchronous reset mid-pulse
      efct_step = 1'b1;
      tick();
      chk("ar_pulse", cpu_en, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_en", cpu_en, 0);
      chk("ar_cnt", step_cnt, 0);
      efct_step = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      efct_step = 1'b1;
      tick();
      chk("ar_press", cpu_en, 1);
      chk("ar_press_cnt", step_cnt, 1);
      tick();
      chk("ar_press2", cpu_en, 0);
      efct_step = 1'b0;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
